mem_interface_unit: RTL and testbench

- Memory-side stage directly upstream of the datapath MDR.
- Holds the MAR, which loads from bus_contents.
- Runs a req/ack handshake with the word-addressed RAM, then returns read data on MDatain for the MDMux. Sends write data from the MDR output to RAM.
- Tells the control sequencer when it is busy and when each transfer completes.

---
 rtl/mem_interface_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_interface_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface_unit.sv
// Memory interface stage: holds the MAR and runs a req/ack handshake with the word-addressed RAM.
// Optional MEM_TIMEOUT_EN adds a REQ watchdog, an ERR state and a sticky mem_err flag.
module mem_interface_unit #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_contents,
  input  logic              MARin,
  input  logic [DATA_W-1:0] MDR_data_out,
  input  logic              Read,
  input  logic              Write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] MDatain,
  output logic              mem_done,
  output logic              busy,
  output logic              mem_err
);

  // state | meaning
  // IDLE  | waiting for Read/Write; only state with busy=0
  // REQ   | mem_req held with frozen address/data until mem_ack
  // DONE  | one-cycle completion pulse on mem_done
  // ERR   | (MEM_TIMEOUT_EN) REQ timed out; pulse mem_done, set mem_err
`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic [DATA_W-1:0]   mdatain_q, mdatain_d;
  logic                start_req;

`ifdef MEM_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                cnt_hit;
  logic                unused_bits;

  assign unused_bits = ^bus_contents[DATA_W-1:ADDR_W];
  // widened so the compare cannot wrap when TIMEOUT is 255
  assign cnt_hit = ({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM;
`else
  logic                unused_bits;

  assign unused_bits = ^{bus_contents[DATA_W-1:ADDR_W], 8'(TIMEOUT)};
`endif

  assign start_req = Read | Write;

  always_comb begin
    state_d   = state_q;
    mar_d     = MARin ? bus_contents[ADDR_W-1:0] : mar_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    req_d     = req_q;
    mdatain_d = mdatain_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          // a simultaneous Read wins; the Write is dropped
          we_d    = ~Read;
          addr_d  = mar_q;
          if (!Read) begin
            wdata_d = MDR_data_out;
          end
`ifdef MEM_TIMEOUT_EN
          cnt_d = 8'd0;
          err_d = 1'b0;
`endif
        end
      end

      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            mdatain_d = mem_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_hit) begin
          state_d = S_ERR;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

`ifdef MEM_TIMEOUT_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      mar_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      req_q     <= 1'b0;
      mdatain_q <= '0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      req_q     <= req_d;
      mdatain_q <= mdatain_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err  = err_q;
  assign mem_done = (state_q == S_DONE) || (state_q == S_ERR);
`else
  assign mem_err  = 1'b0;
  assign mem_done = (state_q == S_DONE);
`endif

  assign busy      = (state_q != S_IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign MDatain   = mdatain_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Bench for mem_interface_unit: vector table, hand-written corner sequences, then random
// transfers against a RAM-plus-last-read model. Timeout section runs when MEM_TIMEOUT_EN is set.
module tb_mem_interface_unit;

  logic        clk;
  logic        clr;
  logic [31:0] bus_contents;
  logic        MARin;
  logic [31:0] MDR_data_out;
  logic        Read;
  logic        Write;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] MDatain;
  logic        mem_done;
  logic        busy;
  logic        mem_err;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ram_m [512];
  logic [31:0] md_model;

  mem_interface_unit #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .clr          (clr),
    .bus_contents (bus_contents),
    .MARin        (MARin),
    .MDR_data_out (MDR_data_out),
    .Read         (Read),
    .Write        (Write),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .MDatain      (MDatain),
    .mem_done     (mem_done),
    .busy         (busy),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          waits;
    bit          noise;
    logic [31:0] noise_bus;
    bit          exp_we;
    logic [31:0] exp_md;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_mar(input logic [8:0] a);
    MARin        = 1'b1;
    bus_contents = ($urandom & 32'hFFFF_FE00) | {23'd0, a};
    @(negedge clk);
    MARin        = 1'b0;
  endtask

  // Called at a negedge with the DUT idle and MAR already holding addr.
  task automatic xfer(input string tag, input bit rd, input bit wr, input logic [8:0] addr,
                      input logic [31:0] wd, input logic [31:0] rdat, input int waits,
                      input bit noise, input logic [31:0] noise_bus,
                      input bit exp_we, input logic [31:0] exp_md);
    Read         = rd;
    Write        = wr;
    MDR_data_out = wd;
    @(negedge clk);
    Read         = 1'b0;
    Write        = 1'b0;
    MDR_data_out = $urandom;
    chk({tag, ".req"},  {31'd0, mem_req}, 32'd1);
    chk({tag, ".we"},   {31'd0, mem_we}, {31'd0, exp_we});
    chk({tag, ".addr"}, {23'd0, mem_addr}, {23'd0, addr});
    if (exp_we) chk({tag, ".wdata"}, mem_wdata, wd);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".done0"}, {31'd0, mem_done}, 32'd0);
    chk({tag, ".err"},  {31'd0, mem_err}, 32'd0);
    for (int w = 0; w <= waits; w++) begin
      mem_ack   = (w == waits);
      mem_rdata = (w == waits) ? rdat : $urandom;
      if (noise) begin
        MARin        = 1'b1;
        bus_contents = noise_bus;
        Write        = 1'b1;
        Read         = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      MARin   = 1'b0;
      Read    = 1'b0;
      Write   = 1'b0;
      if (w < waits) begin
        chk({tag, ".req_hold"},  {31'd0, mem_req}, 32'd1);
        chk({tag, ".addr_hold"}, {23'd0, mem_addr}, {23'd0, addr});
        chk({tag, ".we_hold"},   {31'd0, mem_we}, {31'd0, exp_we});
        chk({tag, ".done_early"}, {31'd0, mem_done}, 32'd0);
      end
    end
    chk({tag, ".done"},    {31'd0, mem_done}, 32'd1);
    chk({tag, ".req_off"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ".busy_d"},  {31'd0, busy}, 32'd1);
    chk({tag, ".mdatain"}, MDatain, exp_md);
    @(negedge clk);
    chk({tag, ".done_1cyc"}, {31'd0, mem_done}, 32'd0);
    chk({tag, ".idle"},      {31'd0, busy}, 32'd0);
    chk({tag, ".req_idle"},  {31'd0, mem_req}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rd:1, wr:0, addr:9'h054, wd:32'h0, rdat:32'h34, waits:0, noise:0,
                noise_bus:32'h0, exp_we:0, exp_md:32'h34};
    vecs[1] = '{rd:0, wr:1, addr:9'h01F, wd:32'hDEADBEEF, rdat:32'h0, waits:3, noise:1,
                noise_bus:32'h2A, exp_we:1, exp_md:32'h34};
    vecs[2] = '{rd:1, wr:1, addr:9'h0A5, wd:32'h11111111, rdat:32'hCAFEF00D, waits:1, noise:0,
                noise_bus:32'h0, exp_we:0, exp_md:32'hCAFEF00D};
    vecs[3] = '{rd:1, wr:0, addr:9'h1FF, wd:32'h0, rdat:32'h5A5A5A5A, waits:2, noise:1,
                noise_bus:32'hFFFF_FE03, exp_we:0, exp_md:32'h5A5A5A5A};
    vecs[4] = '{rd:0, wr:1, addr:9'h000, wd:32'h12345678, rdat:32'h0, waits:0, noise:1,
                noise_bus:32'h77, exp_we:1, exp_md:32'h5A5A5A5A};
    vecs[5] = '{rd:1, wr:0, addr:9'h100, wd:32'h0, rdat:32'h0, waits:3, noise:0,
                noise_bus:32'h0, exp_we:0, exp_md:32'h0};

    clr = 1'b0; bus_contents = '0; MARin = 1'b0; MDR_data_out = '0;
    Read = 1'b0; Write = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 512; i++) ram_m[i] = $urandom;

    repeat (2) @(negedge clk);
    chk("rst.req",  {31'd0, mem_req}, 32'd0);
    chk("rst.we",   {31'd0, mem_we}, 32'd0);
    chk("rst.addr", {23'd0, mem_addr}, 32'd0);
    chk("rst.wdata", mem_wdata, 32'd0);
    chk("rst.mdatain", MDatain, 32'd0);
    chk("rst.done", {31'd0, mem_done}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.err",  {31'd0, mem_err}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load_mar(vecs[i].addr);
      xfer($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
           vecs[i].rdat, vecs[i].waits, vecs[i].noise, vecs[i].noise_bus,
           vecs[i].exp_we, vecs[i].exp_md);
    end

    // back-to-back reads with Read held; MAR reloaded during the first transfer
    load_mar(9'h010);
    Read = 1'b1;
    @(negedge clk);
    chk("b2b.addr0", {23'd0, mem_addr}, 32'h010);
    mem_ack = 1'b1; mem_rdata = 32'hA;
    MARin = 1'b1; bus_contents = 32'h11;
    @(negedge clk);
    mem_ack = 1'b0; MARin = 1'b0;
    chk("b2b.done0", {31'd0, mem_done}, 32'd1);
    chk("b2b.md0", MDatain, 32'hA);
    @(negedge clk);
    chk("b2b.gap_done", {31'd0, mem_done}, 32'd0);
    chk("b2b.gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    Read = 1'b0;
    chk("b2b.req1", {31'd0, mem_req}, 32'd1);
    chk("b2b.addr1", {23'd0, mem_addr}, 32'h011);
    mem_ack = 1'b1; mem_rdata = 32'hB;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b.done1", {31'd0, mem_done}, 32'd1);
    chk("b2b.md1", MDatain, 32'hB);
    @(negedge clk);
    chk("b2b.end_busy", {31'd0, busy}, 32'd0);

    // ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack.md", MDatain, 32'hB);
    chk("idle_ack.busy", {31'd0, busy}, 32'd0);
    chk("idle_ack.done", {31'd0, mem_done}, 32'd0);

    // asynchronous reset in the middle of REQ
    load_mar(9'h033);
    Read = 1'b1;
    @(negedge clk);
    Read = 1'b0;
    chk("rreq.req", {31'd0, mem_req}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("rreq.req_drop", {31'd0, mem_req}, 32'd0);
    chk("rreq.busy", {31'd0, busy}, 32'd0);
    chk("rreq.addr", {23'd0, mem_addr}, 32'd0);
    chk("rreq.md", MDatain, 32'd0);
    chk("rreq.done", {31'd0, mem_done}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rreq.late_ack_busy", {31'd0, busy}, 32'd0);
    chk("rreq.late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("rreq.late_ack_md", MDatain, 32'd0);
    chk("rreq.late_ack_done", {31'd0, mem_done}, 32'd0);
    md_model = 32'd0;

`ifdef MEM_TIMEOUT_EN
    begin
      int reqc;
      load_mar(9'h044);
      Read = 1'b1;
      @(negedge clk);
      Read = 1'b0;
      reqc = 0;
      while (mem_req && reqc < 20) begin
        reqc++;
        @(negedge clk);
      end
      chk("to.req_cycles", reqc, 32'd4);
      if (reqc >= 20) begin
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
      end else begin
        chk("to.err_done", {31'd0, mem_done}, 32'd1);
        chk("to.err_set", {31'd0, mem_err}, 32'd1);
        chk("to.err_busy", {31'd0, busy}, 32'd1);
        chk("to.md_keep", MDatain, md_model);
        @(negedge clk);
        chk("to.err_sticky", {31'd0, mem_err}, 32'd1);
        chk("to.idle_done", {31'd0, mem_done}, 32'd0);
        chk("to.idle_busy", {31'd0, busy}, 32'd0);
      end
      load_mar(9'h045);
      md_model = 32'h99;
      xfer("to.ack_at_limit", 1'b1, 1'b0, 9'h045, 32'h0, 32'h99, 3, 1'b0, 32'h0, 1'b0, md_model);
    end
`endif

    for (int t = 0; t < 40; t++) begin
      bit          rd, wr;
      logic [8:0]  a;
      logic [31:0] wd, rdat;
      int          waits;
      rd    = 1'($urandom_range(0, 1));
      wr    = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a     = 9'($urandom_range(0, 31));
      wd    = $urandom;
      waits = $urandom_range(0, 3);
      rdat  = ram_m[a];
      if (rd) md_model = rdat;
      else    ram_m[a] = wd;
      load_mar(a);
      xfer($sformatf("rnd%0d", t), rd, wr, a, wd, rdat, waits, 1'($urandom_range(0, 1)),
           $urandom, !rd, md_model);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
